// File: rtl/aha_clock_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aha_clock_select_ctrl
//  Purpose  : Sequences the shared clock-select bus of the glitch-free clock
//             switch slices. It accepts a request, holds SELECT stable, waits
//             for the old slice to release EN and then for the new slice to
//             assert it. It reports DONE on success and FAULT on an illegal
//             request or a timeout.
//  Revision : 1.0  initial release
// ============================================================================
module aha_clock_select_ctrl #(
    parameter int NUM_CLKS    = 6,
    parameter int DEFAULT_SEL = 0,
    parameter int TIMEOUT     = 1023
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                REQ_VALID,
    input  logic [2:0]          REQ_SEL,
    output logic                REQ_READY,
    input  logic [NUM_CLKS-1:0] EN_IN,
    output logic [2:0]          SELECT,
    output logic [2:0]          CUR_SEL,
    output logic                BUSY,
    output logic                DONE,
    output logic                FAULT
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] c_timeout     = TW'(TIMEOUT);
    localparam logic [2:0]    c_default_sel = 3'(DEFAULT_SEL);
    localparam logic [3:0]    c_num_clks    = 4'(NUM_CLKS);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_off = 2'd1;
    localparam logic [1:0] c_st_wait_on  = 2'd2;

    // Registered state and its next-state values
    logic [NUM_CLKS-1:0] en_meta_q, en_meta_d;
    logic [NUM_CLKS-1:0] en_s_q, en_s_d;
    logic [1:0]          state_q, state_d;
    logic [2:0]          target_q, target_d;
    logic [2:0]          select_q, select_d;
    logic [2:0]          cur_sel_q, cur_sel_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;

    // Decoded conditions
    logic [7:0]          w_en_wide;
    logic [NUM_CLKS-1:0] w_target_hot;
    logic                w_old_off;
    logic                w_new_on;
    logic                w_timed_out;
    logic                w_req_fire;
    logic                w_req_illegal;

    // State register: reset restarts the power-up confirmation of the default clock
    always_ff @(posedge CLK) begin
        if (RESET) begin
            en_meta_q <= '0;
            en_s_q    <= '0;
            state_q   <= c_st_wait_on;
            target_q  <= c_default_sel;
            select_q  <= c_default_sel;
            cur_sel_q <= c_default_sel;
            timer_q   <= '0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            en_meta_q <= en_meta_d;
            en_s_q    <= en_s_d;
            state_q   <= state_d;
            target_q  <= target_d;
            select_q  <= select_d;
            cur_sel_q <= cur_sel_d;
            timer_q   <= timer_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    // Decode synchronized enables into the wait-phase exit conditions
    always_comb begin
        w_en_wide                 = '0;
        w_en_wide[NUM_CLKS-1:0]   = en_s_q;
        for (int i = 0; i < NUM_CLKS; i++) begin
            w_target_hot[i] = (target_q == 3'(i));
        end
        w_old_off     = ~w_en_wide[cur_sel_q];
        w_new_on      = (en_s_q == w_target_hot);
        w_timed_out   = (timer_q == c_timeout);
        w_req_fire    = REQ_VALID && (state_q == c_st_idle);
        w_req_illegal = ({1'b0, REQ_SEL} >= c_num_clks);
    end

    // Next-state logic: synchronizer, sequencing and the wait-phase timer
    always_comb begin
        en_meta_d = EN_IN;
        en_s_d    = en_meta_q;
        state_d   = state_q;
        target_d  = target_q;
        select_d  = select_q;
        cur_sel_d = cur_sel_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        fault_d   = fault_q;
        case (state_q)
            c_st_idle: begin
                if (w_req_fire) begin
                    if (w_req_illegal) begin
                        fault_d = 1'b1;
                    end else if (REQ_SEL == cur_sel_q) begin
                        fault_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        fault_d  = 1'b0;
                        select_d = REQ_SEL;
                        target_d = REQ_SEL;
                        timer_d  = '0;
                        state_d  = c_st_wait_off;
                    end
                end
            end
            c_st_wait_off: begin
                // A satisfied exit condition beats a simultaneous timeout
                if (w_old_off) begin
                    timer_d = '0;
                    state_d = c_st_wait_on;
                end else if (w_timed_out) begin
                    fault_d = 1'b1;
                    state_d = c_st_idle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            c_st_wait_on: begin
                if (w_new_on) begin
                    cur_sel_d = target_q;
                    done_d    = 1'b1;
                    state_d   = c_st_idle;
                end else if (w_timed_out) begin
                    // SELECT stays at the target; software re-requests
                    fault_d = 1'b1;
                    state_d = c_st_idle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Outputs: all derived directly from registers
    always_comb begin
        REQ_READY = (state_q == c_st_idle);
        BUSY      = (state_q != c_st_idle);
        SELECT    = select_q;
        CUR_SEL   = cur_sel_q;
        DONE      = done_q;
        FAULT     = fault_q;
    end

endmodule
`default_nettype wire
